// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predict/resolve block.
//   - conditional-branch funct3 encodings
//   - 2-bit saturating direction-counter states and their reset value
//   - helpers: branch condition evaluation, counter next-state
package branch_predict_resolve_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_funct3_e;

   typedef enum logic [1:0] {
      CTR_STRONG_NT = 2'b00,
      CTR_WEAK_NT   = 2'b01,
      CTR_WEAK_T    = 2'b10,
      CTR_STRONG_T  = 2'b11
   } ctr_state_e;

   localparam ctr_state_e CTR_RESET = CTR_WEAK_NT;

   // LSB already carries the signed/unsigned less-than result for the type,
   // so the signed and unsigned variants share one rule. 010/011 never take.
   function automatic logic branch_cond(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       lsb);
      logic c;
      c = 1'b0;
      case (f3)
         F3_BEQ:           c = zero;
         F3_BNE:           c = ~zero;
         F3_BLT, F3_BLTU:  c = lsb;
         F3_BGE, F3_BGEU:  c = ~lsb;
         default:          c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic ctr_state_e ctr_next(input ctr_state_e s,
                                           input logic       taken);
      ctr_state_e n;
      n = s;
      case (s)
         CTR_STRONG_NT: n = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
         CTR_WEAK_NT:   n = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
         CTR_WEAK_T:    n = taken ? CTR_STRONG_T : CTR_WEAK_NT;
         CTR_STRONG_T:  n = taken ? CTR_STRONG_T : CTR_WEAK_T;
         default:       n = s;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/branch_predict_resolve_bht_table.sv
// bht_table: DEPTH x 2-bit saturating direction counters.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (all entries -> weak-NT)
//   rd_idx_i       asynchronous read index
//   rd_state_o     counter value at rd_idx_i (pre-update value, no bypass)
//   wr_en_i        apply one saturating update on the next rising edge
//   wr_idx_i       update index
//   wr_taken_i     1 = count up, 0 = count down
module bht_table
   import branch_predict_resolve_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [1:0]       rd_state_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   ctr_state_e ctr_q [DEPTH];
   ctr_state_e wr_state_d;

   always_comb begin
      wr_state_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
      rd_state_o = ctr_q[rd_idx_i];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctr_q <= '{default: CTR_RESET};
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= wr_state_d;
      end
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: decode-stage direction prediction from a BHT and
// execute-stage branch/jump resolution with redirect and a mispredict counter.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   PCD / PredTakenD         decode lookup PC / predicted direction
//   ValidE, StallE           execute slot valid / held
//   JumpE, BranchE           unconditional jump / conditional branch
//   BranchTypeE, Zero, LSB   funct3 and ALU flags for the condition
//   PredTakenE               prediction carried with the execute instruction
//   PCE, PCTargetE, PCPlus4E execute PC, taken target, fall-through
//   RedirectE, RedirectPCE   restart fetch at RedirectPCE (combinational)
//   ClrStat, MispredCnt      clear / saturating redirect count
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned BHT_DEPTH  = 64,
   parameter int unsigned PREDICT_EN = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [XLEN-1:0] PCD,
   output logic            PredTakenD,
   input  logic            ValidE,
   input  logic            StallE,
   input  logic            JumpE,
   input  logic            BranchE,
   input  logic [2:0]      BranchTypeE,
   input  logic            Zero,
   input  logic            LSB,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic [XLEN-1:0] PCPlus4E,
   output logic            RedirectE,
   output logic [XLEN-1:0] RedirectPCE,
   input  logic            ClrStat,
   output logic [15:0]     MispredCnt
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic        active;
   logic        cond;
   logic        actual_taken;
   logic        mispredict;
   logic [15:0] cnt_q, cnt_d;
   logic        unused_pc;

   // Only the index bits of the PCs reach the table.
   assign unused_pc = ^{PCD, PCE};

   always_comb begin
      active       = ValidE & ~StallE;
      cond         = branch_cond(BranchTypeE, Zero, LSB);
      actual_taken = active & ((BranchE & cond) | JumpE);
      mispredict   = active & BranchE & (actual_taken != PredTakenE);
      RedirectE    = (active & JumpE) | mispredict;
      RedirectPCE  = actual_taken ? PCTargetE : PCPlus4E;
   end

   if (PREDICT_EN != 0) begin : g_bht
      logic [1:0] rd_state;
      logic       wr_en;

      // A jump with BranchE also set is treated as a jump: no training.
      assign wr_en = active & BranchE & ~JumpE;

      bht_table #(
         .DEPTH (BHT_DEPTH)
      ) u_bht (
         .clk_i      (CLK),
         .rst_i      (RST),
         .rd_idx_i   (PCD[IDX_W+1:2]),
         .rd_state_o (rd_state),
         .wr_en_i    (wr_en),
         .wr_idx_i   (PCE[IDX_W+1:2]),
         .wr_taken_i (actual_taken)
      );

      assign PredTakenD = rd_state[1];
   end else begin : g_static
      assign PredTakenD = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (ClrStat) begin
         cnt_d = '0;
      end else if (RedirectE && (cnt_q != '1)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign MispredCnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: three instances (default, 4-entry table,
// static not-taken) share one stimulus stream and are checked against a
// behavioural model using integer counters and arithmetic indexing.
module tb_branch_predict_resolve;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] PCD, PCE, PCTargetE, PCPlus4E;
   logic        ValidE, StallE, JumpE, BranchE, Zero, LSB, PredTakenE, ClrStat;
   logic [2:0]  BranchTypeE;

   logic        pred_a, pred_b, pred_c;
   logic        redir_a, redir_b, redir_c;
   logic [31:0] rpc_a, rpc_b, rpc_c;
   logic [15:0] cnt_a, cnt_b, cnt_c;

   int n_checks = 0;
   int n_errors = 0;

   int m_ctr64 [64];
   int m_ctr4  [4];
   int m_cnt;

   always #5 CLK = ~CLK;

   branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(64), .PREDICT_EN(1)) u_dut_a (
      .CLK(CLK), .RST(RST), .PCD(PCD), .PredTakenD(pred_a), .ValidE(ValidE),
      .StallE(StallE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
      .Zero(Zero), .LSB(LSB), .PredTakenE(PredTakenE), .PCE(PCE),
      .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RedirectE(redir_a),
      .RedirectPCE(rpc_a), .ClrStat(ClrStat), .MispredCnt(cnt_a));

   branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(4), .PREDICT_EN(1)) u_dut_b (
      .CLK(CLK), .RST(RST), .PCD(PCD), .PredTakenD(pred_b), .ValidE(ValidE),
      .StallE(StallE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
      .Zero(Zero), .LSB(LSB), .PredTakenE(PredTakenE), .PCE(PCE),
      .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RedirectE(redir_b),
      .RedirectPCE(rpc_b), .ClrStat(ClrStat), .MispredCnt(cnt_b));

   branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(64), .PREDICT_EN(0)) u_dut_c (
      .CLK(CLK), .RST(RST), .PCD(PCD), .PredTakenD(pred_c), .ValidE(ValidE),
      .StallE(StallE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
      .Zero(Zero), .LSB(LSB), .PredTakenE(PredTakenE), .PCE(PCE),
      .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RedirectE(redir_c),
      .RedirectPCE(rpc_c), .ClrStat(ClrStat), .MispredCnt(cnt_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit cond_ref(input logic [2:0] f3, input logic z, input logic l);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4, 3'd6: return l;
         3'd5, 3'd7: return !l;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int idx(input logic [31:0] pc, input int unsigned depth);
      return int'((pc / 4) % depth);
   endfunction

   function automatic int sat_step(input int v, input bit taken);
      if (taken) return (v < 3) ? v + 1 : 3;
      return (v > 0) ? v - 1 : 0;
   endfunction

   task automatic model_reset();
      foreach (m_ctr64[i]) m_ctr64[i] = 1;
      foreach (m_ctr4[i]) m_ctr4[i] = 1;
      m_cnt = 0;
   endtask

   // Called one time unit after a rising edge: checks outputs mid-cycle,
   // then advances the model across the next edge.
   task automatic step();
      bit act, tk, mp, rd;
      logic [31:0] rp;
      #3;
      if (RST) model_reset();
      act = ValidE && !StallE;
      tk  = act && ((BranchE && cond_ref(BranchTypeE, Zero, LSB)) || JumpE);
      mp  = act && BranchE && (tk != PredTakenE);
      rd  = (act && JumpE) || mp;
      rp  = tk ? PCTargetE : PCPlus4E;
      chk("redirect_a", redir_a, rd);
      chk("redirect_b", redir_b, rd);
      chk("redirect_c", redir_c, rd);
      chk("rpc_a", rpc_a, rp);
      chk("rpc_c", rpc_c, rp);
      chk("pred_a", pred_a, m_ctr64[idx(PCD, 64)] >= 2);
      chk("pred_b", pred_b, m_ctr4[idx(PCD, 4)] >= 2);
      chk("pred_c", pred_c, 0);
      chk("cnt_a", cnt_a, m_cnt);
      chk("cnt_b", cnt_b, m_cnt);
      chk("cnt_c", cnt_c, m_cnt);
      @(posedge CLK);
      if (RST) begin
         model_reset();
      end else begin
         if (act && BranchE && !JumpE) begin
            m_ctr64[idx(PCE, 64)] = sat_step(m_ctr64[idx(PCE, 64)], tk);
            m_ctr4[idx(PCE, 4)]   = sat_step(m_ctr4[idx(PCE, 4)], tk);
         end
         if (ClrStat) m_cnt = 0;
         else if (rd && m_cnt < 65535) m_cnt++;
      end
      #1;
   endtask

   task automatic drive(input bit v, input bit s, input bit j, input bit b,
                        input logic [2:0] f3, input bit z, input bit l, input bit pte,
                        input logic [31:0] pcd, input logic [31:0] pce,
                        input logic [31:0] tgt);
      ValidE = v; StallE = s; JumpE = j; BranchE = b; BranchTypeE = f3;
      Zero = z; LSB = l; PredTakenE = pte; PCD = pcd; PCE = pce;
      PCTargetE = tgt; PCPlus4E = pce + 32'd4;
      step();
   endtask

   function automatic logic [31:0] rand_pc();
      return ($urandom & 32'hFFFF_FE00) | ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      RST = 1'b1; ClrStat = 1'b0;
      ValidE = 0; StallE = 0; JumpE = 0; BranchE = 0; BranchTypeE = 3'd0;
      Zero = 0; LSB = 0; PredTakenE = 0;
      PCD = 32'h100; PCE = 32'h0; PCTargetE = 32'h0; PCPlus4E = 32'h4;
      model_reset();
      #3;
      chk("rst_cnt_async", cnt_a, 16'h0);
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;

      // reset state: weak-NT everywhere
      drive(0,0,0,0, 3'd0,0,0,0, 32'h100, 32'h100, 32'h0);
      chk("reset_pred_0x100", pred_a, 0);
      // beq taken twice at 0x100: 01 -> 10 -> 11
      drive(1,0,0,1, 3'd0,1,0,0, 32'h100, 32'h100, 32'h300);
      chk("beq_pred_after_first", pred_a, 1);
      drive(1,0,0,1, 3'd0,1,0,1, 32'h100, 32'h100, 32'h300);
      // bne not-predicted, taken to 0x200
      drive(1,0,0,1, 3'd1,0,0,0, 32'h100, 32'h104, 32'h200);
      // bge predicted taken, LSB=1 -> not taken, fall through
      drive(1,0,0,1, 3'd5,0,1,1, 32'h100, 32'h100, 32'h500);
      // jump, then the same jump stalled
      drive(1,0,1,0, 3'd0,0,0,0, 32'h100, 32'h100, 32'h40);
      drive(1,1,1,0, 3'd0,0,0,0, 32'h100, 32'h100, 32'h40);
      // jump with BranchE also set: redirect, no training
      drive(1,0,1,1, 3'd0,1,0,0, 32'h100, 32'h8, 32'h40);
      // aliasing in the 4-entry table: train via 0x0, read via 0x10
      drive(1,0,0,1, 3'd0,1,0,0, 32'h10, 32'h0, 32'h80);
      drive(1,0,0,1, 3'd0,1,0,0, 32'h10, 32'h0, 32'h80);
      chk("alias_pred_b", pred_b, 1);
      chk("noalias_pred_a", pred_a, 0);
      drive(0,0,0,0, 3'd0,0,0,0, 32'h10, 32'h0, 32'h0);
      // same-cycle lookup and update of one index sees the old value
      drive(1,0,0,1, 3'd1,1,0,0, 32'h10, 32'h10, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pce;
         pce = rand_pc();
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? pce : rand_pc(), pce, $urandom);
         ClrStat = ($urandom_range(0, 99) == 0);
      end
      ClrStat = 1'b0;

      // reset coincident with an update edge: the update is lost
      drive(1,0,0,1, 3'd0,1,0,1, 32'h100, 32'h100, 32'h300);
      drive(1,0,0,1, 3'd0,1,0,1, 32'h100, 32'h100, 32'h300);
      #3; RST = 1'b1;
      @(posedge CLK); model_reset(); #1;
      RST = 1'b0;
      drive(0,0,0,0, 3'd0,0,0,0, 32'h100, 32'h100, 32'h0);
      chk("rst_wins_pred", pred_a, 0);
      chk("rst_wins_cnt", cnt_a, 16'h0);

      // static predictor: taken beq always redirects
      drive(1,0,0,1, 3'd0,1,0,0, 32'h100, 32'h100, 32'h700);
      chk("static_pred_c", pred_c, 0);

      // counter saturation, then clear wins over increment
      ValidE = 1; StallE = 0; JumpE = 1; BranchE = 0; PCTargetE = 32'h40;
      for (int i = 0; i < 65540; i++) begin
         @(posedge CLK);
         if (m_cnt < 65535) m_cnt++;
      end
      #1;
      chk("sat_cnt_a", cnt_a, 16'hFFFF);
      chk("sat_cnt_b", cnt_b, m_cnt);
      ClrStat = 1'b1;
      step();
      ClrStat = 1'b0;
      drive(0,0,0,0, 3'd0,0,0,0, 32'h0, 32'h0, 32'h0);
      chk("clr_cnt_a", cnt_a, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 Parameter XLEN, default 32: width of all PC/target buses.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit counters; power of two, 4..1024.
REQ-003 Parameter PREDICT_EN, default 1: 1 = dynamic BHT prediction; 0 = static not-taken, no table state.
REQ-004 Ports, one per line: name  direction  width  meaning (clock and reset first).
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- PCD  in  XLEN  decode-stage PC used for the lookup.
- PredTakenD  out  1  predicted direction for the branch in decode.
- ValidE  in  1  execute slot holds a real instruction (not a bubble).
- StallE  in  1  execute stage held this cycle.
- JumpE  in  1  unconditional jump in execute.
- BranchE  in  1  conditional branch in execute.
- BranchTypeE  in  3  funct3 of the branch.
- Zero  in  1  ALU zero flag.
- LSB  in  1  ALU compare result bit (signed or unsigned per type).
- PredTakenE  in  1  PredTakenD carried down the pipeline.
- PCE  in  XLEN  execute-stage PC.
- PCTargetE  in  XLEN  branch/jump target.
- PCPlus4E  in  XLEN  fall-through PC.
- RedirectE  out  1  fetch must restart at RedirectPCE; flush F/D.
- RedirectPCE  out  XLEN  restart address.
- ClrStat  in  1  synchronous clear of MispredCnt.
- MispredCnt  out  16  saturating mispredict/redirect count.

Function
REQ-005 Index = PC[log2(BHT_DEPTH)+1:2]; bits [1:0] ignored.
REQ-006 PredTakenD = MSB of counter[index(PCD)], combinational; 0 when PREDICT_EN=0.
REQ-007 Condition: 000 Zero; 001 ~Zero; 100 LSB; 101 ~LSB; 110 LSB; 111 ~LSB; 010/011 0 (not taken).
REQ-008 Active = ValidE & ~StallE; ActualTaken = Active & ((BranchE & Condition) | JumpE).
REQ-009 Mispredict = Active & BranchE & (ActualTaken != PredTakenE).
REQ-010 RedirectE = (Active & JumpE) | Mispredict, combinational, zero added latency.
REQ-011 RedirectPCE = PCTargetE when ActualTaken, else PCPlus4E; value is don't-care when RedirectE=0 but is still driven by the same mux.
REQ-012 Counter update: when Active & BranchE, counter[index(PCE)] increments if taken, decrements if not, saturating at 00 and 11; written on the next edge.
REQ-013 States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; 11+taken stays 11; 00+not-taken stays 00.
REQ-014 Jumps never update the table; JumpE & BranchE both set is illegal and treated as jump (no update).
REQ-015 Same-cycle lookup and update of one index: PredTakenD returns the pre-update value (no bypass).
REQ-016 MispredCnt increments by 1 on each cycle with RedirectE=1, saturates at 16'hFFFF; ClrStat has priority over increment.
REQ-017 StallE=1 or ValidE=0: no redirect, no table update, no count.

Reset
REQ-018 RST=1 asynchronously sets all counters to 01, MispredCnt to 0; RedirectE follows inputs, gated to 0 by REQ-017 once ValidE=0.
REQ-019 Reset asserted coincident with an update edge: reset wins, the update is lost.

Structure
REQ-020 Shared package holds branch funct3 encodings, 2-bit counter state constants and the reset state (01).
REQ-021 One sub-module bht_table: BHT_DEPTH x 2-bit array, 1 async read port, 1 sync saturating-update port; not instantiated when PREDICT_EN=0.

Verification
REQ-022 Reset, then PCD=0x100 -> PredTakenD=0; beq at PCE=0x100 taken twice (Zero=1) -> counter 01->10->11, PredTakenD=1 from the cycle after the first update.
REQ-023 PredTakenE=0, bne, Zero=0, PCTargetE=0x200 -> RedirectE=1, RedirectPCE=0x200, MispredCnt=1.
REQ-024 PredTakenE=1, bge, LSB=1 -> RedirectE=1, RedirectPCE=PCPlus4E, counter decrements.
REQ-025 JumpE=1, PCTargetE=0x40 -> RedirectE=1, RedirectPCE=0x40, table unchanged; with StallE=1 -> RedirectE=0.
REQ-026 BHT_DEPTH=4: PCs 0x0 and 0x10 alias to index 0, shared counter; 0x7FFFF mispredicts -> MispredCnt holds 0xFFFF; ClrStat -> 0.
REQ-027 PREDICT_EN=0: PredTakenD always 0; taken beq always redirects.
